// File: rtl/ram_readout_ctrl.sv
// Read-side controller for the event RAM: replays a block of words from a base address
// and streams them out as valid/ready with an end-of-block marker.
module ram_readout_ctrl #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 25001,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ena,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              ram_dval,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DepthLen = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     in_flight_q;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic [ADDR_W-1:0]        len_q;
  logic [ADDR_W-1:0]        issue_cnt_q;
  logic [ADDR_W-1:0]        send_cnt_q;
  logic [1:0][DATA_W-1:0]   buf_q, buf_d;
  logic [1:0]               count_q, count_d;

  logic                     pop;
  logic                     push;
  logic                     issue;
  logic                     last_issue;
  logic [1:0]               occupancy;
  logic [ADDR_W-1:0]        next_addr;
  logic [ADDR_W-1:0]        len_clamped;
  logic [ADDR_W-1:0]        base_wrapped;

  assign tx_valid = (count_q != 2'd0);
  assign tx_data  = buf_q[0];
  assign tx_last  = tx_valid && (send_cnt_q == len_q - ADDR_W'(1));
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_addr  = rd_addr_q;
  assign rd_ena   = issue;

  always_comb begin
    pop  = tx_valid & tx_ready;
    push = ram_dval & busy_q;
    // Words that will occupy the buffer once this cycle's pop and in-flight read settle.
    occupancy    = count_q + {1'b0, in_flight_q} - {1'b0, pop};
    issue        = (state_q == StRead) && (occupancy < 2'(BUF_DEPTH));
    last_issue   = issue && (issue_cnt_q == len_q - ADDR_W'(1));
    next_addr    = (rd_addr_q == LastAddr) ? '0 : rd_addr_q + ADDR_W'(1);
    len_clamped  = (length > DepthLen) ? DepthLen : length;
    // Out-of-range bases fold back into the RAM so the address never reaches DEPTH.
    base_wrapped = (base_addr > LastAddr) ? base_addr - DepthLen : base_addr;
  end

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        buf_d[count_q[0]] = ram_q;
        count_d           = count_q + 2'd1;
      end
      2'b01: begin
        buf_d[0] = buf_q[1];
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          buf_d[0] = buf_q[1];
          buf_d[1] = ram_q;
        end else begin
          buf_d[0] = ram_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_flight_q <= 1'b0;
      rd_addr_q   <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      send_cnt_q  <= '0;
    end else begin
      in_flight_q <= issue;
      done_q      <= 1'b0;
      if (issue) begin
        rd_addr_q   <= next_addr;
        issue_cnt_q <= issue_cnt_q + ADDR_W'(1);
      end
      if (pop) begin
        send_cnt_q <= send_cnt_q + ADDR_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            issue_cnt_q <= '0;
            send_cnt_q  <= '0;
            len_q       <= len_clamped;
            if (length == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StRead;
              busy_q    <= 1'b1;
              rd_addr_q <= base_wrapped;
            end
          end
        end
        StRead: begin
          if (last_issue) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && tx_last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_readout_ctrl.sv
// Bench for ram_readout_ctrl: behavioural RAM, queue-based expected stream and address order,
// randomized backpressure and transfer parameters.
module tb_ram_readout_ctrl;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 25001;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              busy, done, rd_ena, tx_valid, tx_last;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] ram_q = '0;
  logic              ram_dval = 1'b0;
  logic              tx_ready = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_addr[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                ready_mode = 0;
  int                issued = 0;
  int                sent = 0;
  int                exp_len = 0;
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;

  always #5 clk = ~clk;

  ram_readout_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .BUF_DEPTH(2)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_ena   (rd_ena),
    .ram_q    (ram_q),
    .ram_dval (ram_dval),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last)
  );

  // Registered-output RAM: data one cycle after the read enable.
  always @(posedge clk) begin
    ram_dval <= rd_ena;
    ram_q    <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_ena", 32'(rd_ena), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_last", 32'(tx_last), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_tx_data", 32'(tx_data), 0);
  endtask

  task automatic start_xfer(input int b, input int l);
    int le;
    le = (l > int'(DEPTH)) ? int'(DEPTH) : l;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_addr.delete();
    issued  = 0;
    sent    = 0;
    exp_len = le;
    for (int i = 0; i < le; i++) begin
      exp_addr.push_back((b + i) % int'(DEPTH));
      exp_q.push_back(mem[(b + i) % int'(DEPTH)]);
    end
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    length    = ADDR_W'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    check("done_seen", 32'(done), 1);
    if (done) begin
      check("words_left", 32'(exp_q.size()), 0);
      check("reads_issued", 32'(issued), 32'(exp_len));
      check("words_sent", 32'(sent), 32'(exp_len));
      check("busy_at_done", 32'(busy), 0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
    end
  endtask

  // Downstream ready generator: 0 = always ready, 1 = random, 2 = 1,0,0 repeating.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: tx_ready = 1'($urandom_range(0, 1));
        2: begin
          tx_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Stream and read-port monitor against the expected queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (rd_ena) begin
          issued++;
          if (exp_addr.size() == 0) check("spurious_rd_ena", 32'(rd_ena), 0);
          else check("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
        end
        if (stall_prev) begin
          check("stall_valid", 32'(tx_valid), 1);
          check("stall_data", 32'(tx_data), 32'(stall_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_tx", 32'(tx_valid), 0);
          end else begin
            check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            check("tx_last", 32'(tx_last), 32'(exp_q.size() == 0));
          end
          sent++;
        end
        if (busy) check("outstanding_le_3", 32'((issued - sent) <= 3), 1);
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[100 + i] = 16'(16'hA0 + i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic transfer with exact cycle timing.
    ready_mode = 0;
    start_xfer(100, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("basic_rd_ena", 32'(rd_ena), 32'(k <= 4));
      if (k <= 4) check("basic_rd_addr", 32'(rd_addr), 32'(100 + k - 1));
      check("basic_tx_valid", 32'(tx_valid), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        check("basic_tx_data", 32'(tx_data), 32'(16'hA0 + k - 3));
        check("basic_tx_last", 32'(tx_last), 32'(k == 6));
      end
      check("basic_done", 32'(done), 32'(k == 7));
      check("basic_busy", 32'(busy), 32'(k <= 6));
    end
    check("basic_words_left", 32'(exp_q.size()), 0);

    // Zero length.
    start_xfer(37, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("zero_done", 32'(done), 32'(k == 1));
      check("zero_rd_ena", 32'(rd_ena), 0);
      check("zero_tx_valid", 32'(tx_valid), 0);
      check("zero_busy", 32'(busy), 0);
    end

    // Wrap-around.
    start_xfer(24998, 5);
    wait_done(40);

    // Backpressure 1,0,0 pattern.
    ready_mode = 2;
    start_xfer(0, 8);
    wait_done(100);

    // Start while busy is ignored.
    ready_mode = 1;
    start_xfer(1000, 6);
    repeat (2) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = ADDR_W'(500);
    length    = ADDR_W'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200);

    // Reset after the second word.
    ready_mode = 0;
    start_xfer(2000, 10);
    n = 0;
    while (sent < 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("second_word_seen", 32'(sent >= 2), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_addr.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_tx_valid", 32'(tx_valid), 0);
    end
    start_xfer(3, 3);
    wait_done(40);

    // Randomized transfers.
    for (int t = 0; t < 8; t++) begin
      int b;
      int l;
      ready_mode = int'($urandom_range(0, 2));
      b = (t % 2 == 1) ? int'(DEPTH) - 1 - int'($urandom_range(0, 20))
                       : int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(1, 40));
      start_xfer(b, l);
      wait_done(l * 6 + 20);
    end

    // Length above DEPTH is clamped.
    ready_mode = 0;
    start_xfer(12345, 30000);
    wait_done(25100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_readout_ctrl.md
Name: ram_readout_ctrl

Overview:
- Read-side controller for the single-clock event RAM (16-bit words, addresses 0..25000).
- On a start command it replays a block of stored words, beginning at a programmable base address.
- Drives the RAM read port (rd_addr, rd_ena) and consumes its registered output (q, dval).
- Presents the words as a valid/ready stream with an end-of-block marker to the downstream SFP transmit path, with full backpressure support.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 16, RAM word width.
- DEPTH, 25001, number of RAM words; the last valid address is DEPTH-1.
- BUF_DEPTH, 2, output skid-buffer entries; fixed at 2 in this revision.

Ports:
- clk  in  1  system clock; also clocks the RAM.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM address; sampled with start.
- length  in  ADDR_W  number of words to send; sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.
- rd_addr  out  ADDR_W  RAM read address.
- rd_ena  out  1  RAM read enable.
- ram_q  in  DATA_W  RAM read data, valid when ram_dval=1.
- ram_dval  in  1  RAM read-data valid; arrives 1 cycle after rd_ena.
- tx_data  out  DATA_W  stream data.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  downstream accept.
- tx_last  out  1  marks the final word; qualified by tx_valid.

Behaviour:
- Reset: state=IDLE; busy, done, rd_ena, tx_valid and tx_last = 0; rd_addr and tx_data = 0; buffer and counters cleared.
- Reset mid-transfer: same values as above on the next edge. A ram_dval arriving the cycle after reset is ignored; no word leaks to tx.
- States: IDLE, READ, DRAIN, DONE.
- IDLE -> READ: start=1 and length!=0.
  - Latch base_addr and length; busy=1 from the next cycle.
  - A length greater than DEPTH is clamped to DEPTH.
- IDLE -> DONE: start=1 and length=0. No reads are issued; done pulses the next cycle.
- Start while not in IDLE: ignored, with no effect on the current transfer.
- Read issue (READ only): rd_ena=1 when (buffer_count + in_flight - pop) < 2, where pop = tx_valid & tx_ready.
  - Each issue advances rd_addr.
  - Address wraps DEPTH-1 -> 0. The address is never DEPTH or above.
  - When rd_ena=0, rd_addr holds its value.
- READ -> DRAIN: after the cycle that issues read number `length`.
- Capture: when ram_dval=1 and the controller is busy, push ram_q into the 2-entry FIFO.
  - Overflow cannot occur by construction; the bench asserts this.
- Stream output:
  - tx_data and tx_valid come from the FIFO head registers.
  - The word stays stable while tx_valid=1 and tx_ready=0.
  - tx_last=1 only on the word whose index is length-1.
- Latency: with start accepted at edge 0, the first rd_ena is in cycle 1 and the first ram_dval in cycle 2.
  - First tx_valid is in cycle 3.
  - With tx_ready held at 1, throughput is 1 word/clock with no bubbles.
- DRAIN -> DONE: on the handshake of the tx_last word.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- Counters: an issue counter and a send counter, each ADDR_W bits; neither overflows because length ≤ DEPTH.

Test Plan:
- Basic transfer: base=100, len=4, RAM[100..103]=A0..A3, tx_ready=1 → rd_addr 100..103 on rd_ena cycles 1..4; tx A0..A3 in cycles 3..6; tx_last with A3; done pulse in cycle 7.
- Wrap-around: base=24998, len=5 → rd_addr sequence 24998, 24999, 25000, 0, 1; data order preserved; tx_last on the 5th word.
- Backpressure: base=0, len=8, tx_ready toggling 1,0,0,1,… → no word lost or duplicated; tx_data stable while stalled; at most 2 words buffered plus 1 in flight.
- Zero length: start with len=0 → rd_ena never asserts; done pulses 1 cycle after start; tx_valid stays 0.
- Start while busy: second start with base=500 during a len=6 transfer → ignored; exactly 6 words are sent from the original base.
- Reset mid-transfer: reset asserted after the 2nd word of len=10 → all outputs 0 next cycle; no tx_valid afterward; a new start with len=3 then completes correctly.
